// File: rtl/pipe_scoreboard_pkg.sv
// Shared types and constants for the pipeline scoreboard.
// Holds the entry flag bundle and the forwarding select encoding.
package pipe_scoreboard_pkg;

    localparam int REG_IDX_W_DEF = 5;
    localparam int FWD_SEL_RF    = 0;

    typedef struct packed {
        logic valid;
        logic wben;
        logic load;
    } sb_flags_t;

    // Entry j at issue time sits in entry j+1 when the consumer is in EX.
    // The last entry retires on that edge, so it falls back to the regfile.
    function automatic int unsigned fwd_sel(
        input logic        hit,
        input int unsigned idx,
        input int unsigned stages
    );
        if (hit && ((idx + 1) < stages)) begin
            return idx + 1;
        end
        return FWD_SEL_RF;
    endfunction

endpackage

// File: rtl/pipe_scoreboard_match.sv
// Youngest-match priority encoder over the scoreboard entries.
// Returns hit, index of the smallest matching entry and its load flag.
module pipe_sb_match
    import pipe_scoreboard_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int IDX_W     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  sb_flags_t [STAGES-1:0]                flags,
    input  logic      [STAGES-1:0][REG_IDX_W-1:0] rd,
    input  logic      [REG_IDX_W-1:0]             src,
    input  logic                                  used,
    output logic                                  hit,
    output logic      [IDX_W-1:0]                 idx,
    output logic                                  load
);

    // Scan oldest to youngest so the smallest index overwrites last.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        load = 1'b0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            if (flags[j].valid && flags[j].wben && (rd[j] != '0) &&
                (rd[j] == src) && used) begin
                hit  = 1'b1;
                idx  = IDX_W'(j);
                load = flags[j].load;
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard beside the ID/EX boundary.
// Define PIPE_SB_DIV_EN to enable the multi-cycle divide hold of EX.
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int REG_IDX_W  = REG_IDX_W_DEF,
    parameter int DIV_CYCLES = 8,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid_i,
    input  logic [REG_IDX_W-1:0] issue_rs1_i,
    input  logic [REG_IDX_W-1:0] issue_rs2_i,
    input  logic                 issue_rs1_used_i,
    input  logic                 issue_rs2_used_i,
    input  logic [REG_IDX_W-1:0] issue_rd_i,
    input  logic                 issue_wben_i,
    input  logic                 issue_load_i,
    input  logic                 issue_div_i,
    input  logic                 flush_i,
    output logic                 stalln_pc_o,
    output logic                 stalln_id_o,
    output logic                 issue_fire_o,
    output logic                 ex_valid_o,
    output logic                 ex_hold_o,
    output logic [SEL_W-1:0]     fwd_rs1_sel_o,
    output logic [SEL_W-1:0]     fwd_rs2_sel_o,
    output logic [STAGES-1:0]    stage_valid_o,
    output logic                 div_busy_o
);

    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    sb_flags_t [STAGES-1:0]                flags_q;
    logic      [STAGES-1:0][REG_IDX_W-1:0] rd_q;
    logic      [SEL_W-1:0]                 sel1_q;
    logic      [SEL_W-1:0]                 sel2_q;

    logic             hit1;
    logic             hit2;
    logic             ld1;
    logic             ld2;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx2;
    logic             load_use;
    logic             fire;
    logic             ex_hold;

    pipe_sb_match #(
        .STAGES   (STAGES),
        .REG_IDX_W(REG_IDX_W),
        .IDX_W    (IDX_W)
    ) u_match_rs1 (
        .flags(flags_q),
        .rd   (rd_q),
        .src  (issue_rs1_i),
        .used (issue_rs1_used_i),
        .hit  (hit1),
        .idx  (idx1),
        .load (ld1)
    );

    pipe_sb_match #(
        .STAGES   (STAGES),
        .REG_IDX_W(REG_IDX_W),
        .IDX_W    (IDX_W)
    ) u_match_rs2 (
        .flags(flags_q),
        .rd   (rd_q),
        .src  (issue_rs2_i),
        .used (issue_rs2_used_i),
        .hit  (hit2),
        .idx  (idx2),
        .load (ld2)
    );

    // A load still in EX cannot feed the instruction in ID this cycle.
    assign load_use = issue_valid_i &
                      ((hit1 & (idx1 == '0) & ld1) |
                       (hit2 & (idx2 == '0) & ld2));

    assign fire = issue_valid_i & ~flush_i & ~load_use & ~ex_hold;

    // A flushed instruction is dead, so its load-use must not stall.
    assign stalln_pc_o   = ~((load_use & ~flush_i) | ex_hold);
    assign stalln_id_o   = stalln_pc_o;
    assign issue_fire_o  = fire;
    assign ex_valid_o    = flags_q[0].valid;
    assign ex_hold_o     = ex_hold;
    assign div_busy_o    = ex_hold;
    assign fwd_rs1_sel_o = sel1_q;
    assign fwd_rs2_sel_o = sel2_q;

    // Per-entry valid bits for the surrounding pipeline registers.
    always_comb begin
        stage_valid_o = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_valid_o[i] = flags_q[i].valid;
        end
    end

    // Advance the in-flight entries; on hold EX keeps its entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= '0;
            rd_q    <= '0;
        end else begin
            for (int i = STAGES - 1; i >= 2; i--) begin
                flags_q[i] <= flags_q[i-1];
                rd_q[i]    <= rd_q[i-1];
            end
            if (ex_hold) begin
                flags_q[1] <= '0;
                rd_q[1]    <= '0;
            end else begin
                flags_q[1] <= flags_q[0];
                rd_q[1]    <= rd_q[0];
                if (fire) begin
                    flags_q[0] <= '{valid: 1'b1,
                                    wben:  issue_wben_i,
                                    load:  issue_load_i};
                    rd_q[0]    <= issue_rd_i;
                end else begin
                    flags_q[0] <= '0;
                    rd_q[0]    <= '0;
                end
            end
        end
    end

    // Register the forwarding selects so they line up with EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel1_q <= SEL_W'(FWD_SEL_RF);
            sel2_q <= SEL_W'(FWD_SEL_RF);
        end else if (!ex_hold) begin
            if (fire) begin
                sel1_q <= SEL_W'(fwd_sel(hit1, int'(idx1), STAGES));
                sel2_q <= SEL_W'(fwd_sel(hit2, int'(idx2), STAGES));
            end else begin
                sel1_q <= SEL_W'(FWD_SEL_RF);
                sel2_q <= SEL_W'(FWD_SEL_RF);
            end
        end
    end

`ifdef PIPE_SB_DIV_EN
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count the remaining EX cycles of an in-flight divide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (fire && issue_div_i) begin
            cnt_q <= CNT_W'(DIV_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign ex_hold = (cnt_q != '0);
`else
    logic unused_div;

    assign unused_div = issue_div_i | (DIV_CYCLES == 0);
    assign ex_hold    = 1'b0;
`endif

`ifndef SYNTHESIS
    // A divide is never a jump, so a flush cannot land during a hold.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(flush_i && ex_hold))
            else $error("pipe_scoreboard: flush_i asserted during ex_hold");
        end
    end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed plan plus random traffic.
// A stage-list reference model supplies every expected value.
module tb_pipe_scoreboard;

    localparam int STAGES = 3;
    localparam int RW     = 5;
    localparam int DIVC   = 8;
    localparam int SW     = $clog2(STAGES + 1);
`ifdef PIPE_SB_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          rs1_used;
    logic          rs2_used;
    logic [RW-1:0] rd;
    logic          wben;
    logic          load;
    logic          div;
    logic          flush;
    logic          stalln_pc;
    logic          stalln_id;
    logic          issue_fire;
    logic          ex_valid;
    logic          ex_hold;
    logic [SW-1:0] sel1;
    logic [SW-1:0] sel2;
    logic [STAGES-1:0] stage_valid;
    logic          div_busy;

    always #5 clk = ~clk;

    pipe_scoreboard #(
        .STAGES    (STAGES),
        .REG_IDX_W (RW),
        .DIV_CYCLES(DIVC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid_i   (issue_valid),
        .issue_rs1_i     (rs1),
        .issue_rs2_i     (rs2),
        .issue_rs1_used_i(rs1_used),
        .issue_rs2_used_i(rs2_used),
        .issue_rd_i      (rd),
        .issue_wben_i    (wben),
        .issue_load_i    (load),
        .issue_div_i     (div),
        .flush_i         (flush),
        .stalln_pc_o     (stalln_pc),
        .stalln_id_o     (stalln_id),
        .issue_fire_o    (issue_fire),
        .ex_valid_o      (ex_valid),
        .ex_hold_o       (ex_hold),
        .fwd_rs1_sel_o   (sel1),
        .fwd_rs2_sel_o   (sel2),
        .stage_valid_o   (stage_valid),
        .div_busy_o      (div_busy)
    );

    typedef struct {
        bit v;
        int rd;
        bit wb;
        bit ld;
    } ent_t;

    ent_t m_ent[STAGES];
    int   m_sel1;
    int   m_sel2;
    int   cyc;
    int   div_at;
    bit   div_on;

    int n_chk  = 0;
    int n_fail = 0;

    bit last_fire;
    bit last_stalln;
    bit last_hold;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int youngest(input int src, input bit used);
        for (int j = 0; j < STAGES; j++) begin
            if (m_ent[j].v && m_ent[j].wb && m_ent[j].rd != 0 &&
                m_ent[j].rd == src && used)
                return j;
        end
        return -1;
    endfunction

    function automatic bit m_hold();
        return DIV_EN && div_on && ((cyc - div_at) < (DIVC - 1));
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < STAGES; i++) m_ent[i] = '{0, 0, 0, 0};
        m_sel1 = 0;
        m_sel2 = 0;
        div_on = 0;
    endfunction

    // One clock: check all outputs against the model, then advance both.
    task automatic cycle();
        int j1, j2, s1, s2;
        bit lu, hold, fire, stn;
        logic [STAGES-1:0] sv;
        ent_t nw;
        #2;
        hold = m_hold();
        j1 = youngest(int'(rs1), rs1_used);
        j2 = youngest(int'(rs2), rs2_used);
        lu = issue_valid && m_ent[0].ld && (j1 == 0 || j2 == 0);
        fire = issue_valid && !flush && !lu && !hold;
        stn = !((lu && !flush) || hold);
        s1 = (j1 >= 0 && j1 + 1 < STAGES) ? j1 + 1 : 0;
        s2 = (j2 >= 0 && j2 + 1 < STAGES) ? j2 + 1 : 0;
        for (int i = 0; i < STAGES; i++) sv[i] = m_ent[i].v;
        chk("stalln_pc", stalln_pc, stn);
        chk("stalln_id", stalln_id, stn);
        chk("fire", issue_fire, fire);
        chk("ex_valid", ex_valid, m_ent[0].v);
        chk("ex_hold", ex_hold, hold);
        chk("div_busy", div_busy, hold);
        chk("sel1", sel1, m_sel1);
        chk("sel2", sel2, m_sel2);
        chk("stage_valid", stage_valid, sv);
        last_fire   = issue_fire;
        last_stalln = stalln_id;
        last_hold   = ex_hold;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_clear();
        end else if (hold) begin
            for (int i = STAGES - 1; i >= 2; i--) m_ent[i] = m_ent[i-1];
            m_ent[1] = '{0, 0, 0, 0};
        end else begin
            for (int i = STAGES - 1; i >= 1; i--) m_ent[i] = m_ent[i-1];
            nw = '{fire, fire ? int'(rd) : 0, fire && wben, fire && load};
            m_ent[0] = nw;
            m_sel1 = fire ? s1 : 0;
            m_sel2 = fire ? s2 : 0;
            if (fire && div) begin
                div_on = 1;
                div_at = cyc;
            end
        end
        #1;
    endtask

    task automatic set_in(input bit v, input int r1, input bit u1,
                          input int r2, input bit u2, input int d,
                          input bit w, input bit l, input bit dv,
                          input bit fl);
        issue_valid = v;
        rs1 = RW'(r1);
        rs1_used = u1;
        rs2 = RW'(r2);
        rs2_used = u2;
        rd = RW'(d);
        wben = w;
        load = l;
        div = dv;
        flush = fl;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int stalls;
    int holds;
    int fire_at;

    initial begin
        cyc = 0;
        div_at = 0;
        m_clear();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_stalln", stalln_pc, 1);
        rst_n = 1'b1;

        // back-to-back dependency: addi x5 ; add x6, x5, x5
        set_in(1, 1, 1, 0, 0, 5, 1, 0, 0, 0);
        cycle();
        set_in(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
        cycle();
        chk("b2b_no_stall", last_stalln, 1);
        chk("b2b_sel1", sel1, 1);
        chk("b2b_sel2", sel2, 1);
        idle();
        cycle();

        // load-use: ld x7 ; add x8, x7, x0
        set_in(1, 2, 1, 0, 0, 7, 1, 1, 0, 0);
        cycle();
        set_in(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
        stalls = 0;
        fire_at = 0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (!last_stalln) stalls++;
            if (last_fire) begin
                fire_at = k;
                break;
            end
        end
        chk("lu_stall_cycles", stalls, 1);
        chk("lu_fire_attempt", fire_at, 2);
        chk("lu_sel1", sel1, 2);
        chk("lu_sel2", sel2, 0);
        idle();
        cycle();

        // x0 producer (a load, so any false match would also stall)
        set_in(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        set_in(1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        cycle();
        chk("x0_no_stall", last_stalln, 1);
        chk("x0_sel1", sel1, 0);
        chk("x0_sel2", sel2, 0);

        // wben=0 producer
        set_in(1, 1, 1, 0, 0, 9, 0, 1, 0, 0);
        cycle();
        set_in(1, 9, 1, 9, 1, 10, 1, 0, 0, 0);
        cycle();
        chk("nowb_no_stall", last_stalln, 1);
        chk("nowb_sel1", sel1, 0);
        chk("nowb_sel2", sel2, 0);
        idle();
        cycle();

        // flush during load-use
        set_in(1, 1, 1, 0, 0, 3, 1, 1, 0, 0);
        cycle();
        set_in(1, 3, 1, 0, 0, 4, 1, 0, 0, 1);
        cycle();
        chk("flush_stalln_pc", last_stalln, 1);
        chk("flush_fire", last_fire, 0);
        chk("flush_ex_bubble", ex_valid, 0);
        idle();
        cycle();

        // divide followed by an independent instruction
        set_in(1, 1, 1, 2, 1, 4, 1, 0, 1, 0);
        cycle();
        set_in(1, 11, 1, 12, 1, 13, 1, 0, 0, 0);
        holds = 0;
        fire_at = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (last_hold) holds++;
            if (last_fire) begin
                fire_at = k;
                break;
            end
        end
        chk("div_hold_cycles", holds, DIV_EN ? DIVC - 1 : 0);
        chk("div_next_fire", fire_at, DIV_EN ? DIVC : 1);
        idle();
        repeat (DIVC) cycle();

        // reset in the middle of a divide
        set_in(1, 1, 1, 2, 1, 4, 1, 0, 1, 0);
        cycle();
        idle();
        repeat (3) cycle();
        chk("div_busy_mid", div_busy, DIV_EN);
        rst_n = 1'b0;
        cycle();
        chk("rst_div_busy", div_busy, 0);
        chk("rst_valid", stage_valid, 0);
        rst_n = 1'b1;

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
                   0);
            if (!m_hold()) flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
